// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: branch/jump redirect, data-memory req/ack sequencing
// with upstream stall, and the registered MEM/WB fields for write-back.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15,  // REQ cycles allowed before forced completion (1..255)
  parameter int unsigned CNT_W   = 32   // width of the stall-cycle counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite,
  input  logic             MemtoReg,
  input  logic             Jump,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic             Branch,
  input  logic [31:0]      JumpV,
  input  logic [31:0]      OutBranch,
  input  logic             zflag,
  input  logic [31:0]      AluRes,
  input  logic [31:0]      Data2,
  input  logic [4:0]       writeReg,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             stall,
  output logic             pc_src,
  output logic [31:0]      pc_target,
  output logic             wb_RegWrite,
  output logic             wb_MemtoReg,
  output logic [31:0]      wb_ReadData,
  output logic [31:0]      wb_AluRes,
  output logic [4:0]       wb_writeReg,
  output logic             misalign,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] to_cnt;
  logic       mem_op;
  logic       aligned;
  logic       start_acc;
  logic       ack_hit;
  logic       to_hit;

  assign mem_op    = MemRead | MemWrite;
  assign aligned   = (AluRes[1:0] == 2'b00);
  assign start_acc = (state == IDLE) && mem_op && aligned;
  // An ack counts only while a request is outstanding; stray acks elsewhere are ignored.
  assign ack_hit   = (state == REQ) && mem_ack;
  assign to_hit    = (state == REQ) && !mem_ack && (to_cnt == 8'(TIMEOUT - 1));

  // Stall is forced low while in reset so upstream is never frozen by a stale EX/MEM op.
  assign stall     = !rst && ((state == REQ) || start_acc);
  assign pc_src    = !stall && (Jump || (Branch && zflag));
  assign pc_target = Jump ? JumpV : OutBranch;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_acc) state_nxt = REQ;
      REQ:     if (ack_hit || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request interface and REQ-cycle timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      to_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_acc) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;  // store wins when both MemRead and MemWrite are set
            mem_addr  <= AluRes;
            mem_wdata <= Data2;
            to_cnt    <= '0;
          end
        end
        REQ: begin
          if (ack_hit || to_hit) mem_req <= 1'b0;
          else                   to_cnt  <= to_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Error flags: one-cycle misalign pulse, sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      misalign <= (state == IDLE) && mem_op && !aligned;
      if (to_hit) timeout_err <= 1'b1;
    end
  end

  // MEM/WB pipeline register: pass-through, bubbles while stalled, completion in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_RegWrite <= 1'b0;
      wb_MemtoReg <= 1'b0;
      wb_ReadData <= '0;
      wb_AluRes   <= '0;
      wb_writeReg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!mem_op) begin
            wb_RegWrite <= RegWrite;
            wb_MemtoReg <= MemtoReg;
            wb_AluRes   <= AluRes;
            wb_writeReg <= writeReg;
          end else begin
            // Misaligned op is dropped, aligned op starts a bubble.
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
          end
        end
        REQ: begin
          wb_RegWrite <= 1'b0;
          wb_MemtoReg <= 1'b0;
          if (!mem_we) begin
            if (ack_hit)     wb_ReadData <= mem_rdata;
            else if (to_hit) wb_ReadData <= '0;
          end
        end
        DONE: begin
          wb_RegWrite <= RegWrite && !mem_we;
          wb_MemtoReg <= MemtoReg;
          wb_AluRes   <= AluRes;
          wb_writeReg <= writeReg;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))   stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
